// File: rtl/beep_rhythm_gen_if.sv
// Control and status bundle for the buzzer rhythm generator.
// Ports (master = tempo controller, slave = beep_rhythm_gen):
//   en, restart, bpm, bar_len        tempo control, driven by the master
//   tick, beat, downbeat             1-cycle rhythm pulses, driven by the slave
//   sub_idx, beat_idx, bar_cnt       position of the tick just emitted
interface beep_rhythm_gen_if #(
    parameter int SUBDIV = 4,
    parameter int BPM_W  = 9
);
    localparam int SUB_W = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;

    logic             en;
    logic             restart;
    logic [BPM_W-1:0] bpm;
    logic [2:0]       bar_len;
    logic             tick;
    logic             beat;
    logic             downbeat;
    logic [SUB_W-1:0] sub_idx;
    logic [2:0]       beat_idx;
    logic [15:0]      bar_cnt;

    modport master (
        output en, restart, bpm, bar_len,
        input  tick, beat, downbeat, sub_idx, beat_idx, bar_cnt
    );

    modport slave (
        input  en, restart, bpm, bar_len,
        output tick, beat, downbeat, sub_idx, beat_idx, bar_cnt
    );
endinterface

// File: rtl/beep_rhythm_gen.sv
// Programmable tempo generator for the buzzer subsystem.
// A fractional phase accumulator adds bpm*SUBDIV every enabled cycle and
// wraps at 60*CLK_HZ, so the mean tick rate is exactly bpm*SUBDIV/60 Hz
// without a divider and without long-term drift.
// Ports:
//   clk_50MHz  system clock
//   rst_n      synchronous reset, active HIGH (1 = reset) despite the name
//   bus        beep_rhythm_gen_if slave: en/restart/bpm/bar_len in,
//              tick/beat/downbeat pulses and sub_idx/beat_idx/bar_cnt out
module beep_rhythm_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int SUBDIV = 4,
    parameter int BPM_W  = 9,
    parameter int ACC_W  = 33
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    beep_rhythm_gen_if.slave  bus
);
    localparam int SUB_W = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
    localparam logic [ACC_W-1:0] THRESH  = ACC_W'(64'(CLK_HZ) * 64'd60);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUBDIV - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUB_W-1:0] next_sub_q, next_sub_d;
    logic [2:0]       next_beat_q, next_beat_d;
    logic             tick_q, tick_d;
    logic             beat_q, beat_d;
    logic             downbeat_q, downbeat_d;
    logic [SUB_W-1:0] sub_idx_q, sub_idx_d;
    logic [2:0]       beat_idx_q, beat_idx_d;
    logic [15:0]      bar_cnt_q, bar_cnt_d;

    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic [2:0]       eff_len;
    logic [3:0]       beat_inc;
    logic             is_down;

    assign inc      = ACC_W'(bus.bpm) * ACC_W'(SUBDIV);
    assign sum      = acc_q + inc;
    assign eff_len  = (bus.bar_len == 3'd0) ? 3'd1 : bus.bar_len;
    // One extra bit so next_beat+1 can reach 8 without wrapping before the compare.
    assign beat_inc = {1'b0, next_beat_q} + 4'd1;
    assign is_down  = (next_sub_q == '0) && (next_beat_q == 3'd0);

    always_comb begin
        acc_d       = acc_q;
        next_sub_d  = next_sub_q;
        next_beat_d = next_beat_q;
        tick_d      = 1'b0;
        beat_d      = 1'b0;
        downbeat_d  = 1'b0;
        sub_idx_d   = sub_idx_q;
        beat_idx_d  = beat_idx_q;
        bar_cnt_d   = bar_cnt_q;

        if (bus.restart) begin
            acc_d       = '0;
            next_sub_d  = '0;
            next_beat_d = 3'd0;
            sub_idx_d   = '0;
            beat_idx_d  = 3'd0;
            bar_cnt_d   = 16'd0;
        end else if (bus.en) begin
            if (sum >= THRESH) begin
                // Remainder is kept so the phase error never accumulates.
                acc_d      = sum - THRESH;
                tick_d     = 1'b1;
                beat_d     = (next_sub_q == '0);
                downbeat_d = is_down;
                sub_idx_d  = next_sub_q;
                beat_idx_d = next_beat_q;
                if (next_sub_q == SUB_MAX) begin
                    next_sub_d = '0;
                    // bar_len is sampled here, so a mid-bar change takes
                    // effect at the next beat boundary.
                    if (beat_inc >= {1'b0, eff_len}) begin
                        next_beat_d = 3'd0;
                    end else begin
                        next_beat_d = beat_inc[2:0];
                    end
                end else begin
                    next_sub_d = next_sub_q + SUB_W'(1);
                end
                if (is_down && (bar_cnt_q != 16'hFFFF)) begin
                    bar_cnt_d = bar_cnt_q + 16'd1;
                end
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst_n) begin
            acc_q       <= '0;
            next_sub_q  <= '0;
            next_beat_q <= 3'd0;
            tick_q      <= 1'b0;
            beat_q      <= 1'b0;
            downbeat_q  <= 1'b0;
            sub_idx_q   <= '0;
            beat_idx_q  <= 3'd0;
            bar_cnt_q   <= 16'd0;
        end else begin
            acc_q       <= acc_d;
            next_sub_q  <= next_sub_d;
            next_beat_q <= next_beat_d;
            tick_q      <= tick_d;
            beat_q      <= beat_d;
            downbeat_q  <= downbeat_d;
            sub_idx_q   <= sub_idx_d;
            beat_idx_q  <= beat_idx_d;
            bar_cnt_q   <= bar_cnt_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.beat     = beat_q;
    assign bus.downbeat = downbeat_q;
    assign bus.sub_idx  = sub_idx_q;
    assign bus.beat_idx = beat_idx_q;
    assign bus.bar_cnt  = bar_cnt_q;
endmodule

// File: tb/tb_beep_rhythm_gen.sv
// Directed bench for beep_rhythm_gen with CLK_HZ=100 (threshold 6000),
// SUBDIV=4. Inputs change and outputs are sampled on the falling edge.
module tb_beep_rhythm_gen;
    localparam int SUBDIV = 4;

    logic clk_50MHz;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   m_sub, m_beat, m_bar;
    int   seen;

    beep_rhythm_gen_if #(.SUBDIV(SUBDIV), .BPM_W(9)) bus ();

    beep_rhythm_gen #(
        .CLK_HZ(100), .SUBDIV(SUBDIV), .BPM_W(9), .ACC_W(33)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tick"}, 32'(bus.tick), 0);
        chk({tag, "_beat"}, 32'(bus.beat), 0);
        chk({tag, "_downbeat"}, 32'(bus.downbeat), 0);
        chk({tag, "_sub_idx"}, 32'(bus.sub_idx), 0);
        chk({tag, "_beat_idx"}, 32'(bus.beat_idx), 0);
        chk({tag, "_bar_cnt"}, 32'(bus.bar_cnt), 0);
    endtask

    task automatic m_clear();
        m_sub  = 0;
        m_beat = 0;
        m_bar  = 0;
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk_50MHz);
            n++;
        end while (bus.tick !== 1'b1 && n < max);
    endtask

    // Wait for the next tick, check its spacing and position against the
    // bench's expected position, then advance that position.
    task automatic expect_tick(input string tag, input int exp_n);
        int n;
        int eff;
        wait_tick(100, n);
        chk({tag, "_interval"}, 32'(n), 32'(exp_n));
        chk({tag, "_tick"}, 32'(bus.tick), 1);
        chk({tag, "_sub_idx"}, 32'(bus.sub_idx), 32'(m_sub));
        chk({tag, "_beat_idx"}, 32'(bus.beat_idx), 32'(m_beat));
        chk({tag, "_beat"}, 32'(bus.beat), (m_sub == 0) ? 1 : 0);
        chk({tag, "_downbeat"}, 32'(bus.downbeat), (m_sub == 0 && m_beat == 0) ? 1 : 0);
        if (m_sub == 0 && m_beat == 0) m_bar++;
        chk({tag, "_bar_cnt"}, 32'(bus.bar_cnt), 32'(m_bar));
        if (m_sub == SUBDIV - 1) begin
            m_sub = 0;
            eff = (bus.bar_len == 3'd0) ? 1 : int'(bus.bar_len);
            m_beat = (m_beat + 1 >= eff) ? 0 : m_beat + 1;
        end else begin
            m_sub++;
        end
    endtask

    initial begin
        int iv70 [7] = '{22, 21, 22, 21, 22, 21, 21};

        rst_n       = 1'b1;
        bus.en      = 1'b0;
        bus.restart = 1'b0;
        bus.bpm     = 9'd60;
        bus.bar_len = 3'd4;
        m_clear();
        repeat (3) @(negedge clk_50MHz);
        chk_idle("reset");

        // bpm=60: inc=240, one tick every 25 enabled cycles.
        rst_n  = 1'b0;
        bus.en = 1'b1;
        expect_tick("t1_first", 25);
        @(negedge clk_50MHz);
        chk("t1_tick_drop", 32'(bus.tick), 0);
        expect_tick("t1_second", 24);
        for (int k = 2; k <= 16; k++) expect_tick("t1_run", 25);
        chk("t1_bar2", 32'(bus.bar_cnt), 2);

        // 10 enabled cycles (acc=2400), 50 paused, then 15 more to reach 6000.
        repeat (10) @(negedge clk_50MHz);
        bus.en = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk_50MHz);
            if (bus.tick || bus.beat || bus.downbeat) seen = 1;
        end
        chk("t3_no_pulse_paused", 32'(seen), 0);
        chk("t3_sub_hold", 32'(bus.sub_idx), 0);
        chk("t3_bar_hold", 32'(bus.bar_cnt), 2);
        bus.en = 1'b1;
        expect_tick("t3_resume", 15);

        // Advance to beat 2 of the bar, then restart.
        for (int k = 18; k <= 24; k++) expect_tick("t4_run", 25);
        chk("t4_mid_bar", 32'(bus.beat_idx), 2);
        bus.restart = 1'b1;
        @(negedge clk_50MHz);
        bus.restart = 1'b0;
        chk_idle("t4_restart");
        m_clear();
        expect_tick("t4_first", 25);

        // bar_len=0 behaves as 1: every beat is a downbeat.
        bus.bar_len = 3'd0;
        for (int k = 1; k <= 8; k++) expect_tick("t5_len0", 25);
        chk("t5_len0_bars", 32'(bus.bar_cnt), 3);
        // 4 -> 2 while in beat 2: the next beat wraps instead of reaching 3.
        bus.bar_len = 3'd4;
        for (int k = 9; k <= 16; k++) expect_tick("t5_len4", 25);
        chk("t5_at_beat2", 32'(bus.beat_idx), 2);
        bus.bar_len = 3'd2;
        for (int k = 17; k <= 20; k++) expect_tick("t5_shrink", 25);
        chk("t5_shrink_down", 32'(bus.downbeat), 1);
        chk("t5_shrink_bars", 32'(bus.bar_cnt), 4);
        // 4 -> 2 while in beat 3: the next beat is a downbeat.
        bus.bar_len = 3'd4;
        for (int k = 21; k <= 32; k++) expect_tick("t5_len4b", 25);
        chk("t5_at_beat3", 32'(bus.beat_idx), 3);
        bus.bar_len = 3'd2;
        for (int k = 33; k <= 36; k++) expect_tick("t5_wrap", 25);
        chk("t5_wrap_idx", 32'(bus.beat_idx), 0);
        chk("t5_wrap_bars", 32'(bus.bar_cnt), 5);

        // Reset wins over restart/en with a fast tempo loaded.
        rst_n       = 1'b1;
        bus.restart = 1'b1;
        bus.en      = 1'b1;
        bus.bpm     = 9'd511;
        @(negedge clk_50MHz);
        chk_idle("t6_reset");

        // bpm=70: inc=280, intervals follow the 22/21 remainder pattern.
        rst_n       = 1'b0;
        bus.restart = 1'b0;
        bus.bpm     = 9'd70;
        bus.bar_len = 3'd4;
        m_clear();
        for (int k = 0; k < 7; k++) expect_tick("t2_bpm70", iv70[k]);

        // acc=2800 after 10 cycles; bpm=0 must freeze it, so bpm=60 needs 14.
        repeat (10) @(negedge clk_50MHz);
        bus.bpm = 9'd0;
        seen = 0;
        repeat (10000) begin
            @(negedge clk_50MHz);
            if (bus.tick) seen = 1;
        end
        chk("t6_bpm0_no_tick", 32'(seen), 0);
        bus.bpm = 9'd60;
        expect_tick("t6_phase_kept", 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
